// File: rtl/fjt_pkg.sv
// Shared definitions for the fork/join timer: controller states and run-mode encodings.
package fjt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_PAR = 2'd1,
    ST_RUN_SEQ = 2'd2,
    ST_JOIN    = 2'd3
  } fjt_state_e;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

endpackage

// File: rtl/fjt_chan_timer.sv
// One channel down-counter: loads its delay (0 counts as 1), counts while enabled, expire is a
// combinational pulse on the edge the count runs out; kill clears it with no expire. No backpressure.
module fjt_chan_timer #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  input  logic          kill_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // A count of 1 means this edge is the last one of the delay.
  assign expire_o = en_i && !kill_i && (cnt_q == CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (kill_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (load_val_i == '0) ? CW'(1) : load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fork_join_timer.sv
// Fork/join delay timer: channels fire in parallel or chained in index order; done/aborted one cycle
// after the run ends, start ignored while busy. Optional elapsed counter under FJT_ELAPSED_EN.
module fork_join_timer
  import fjt_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [NCH-1:0]               ch_en,
  input  logic [NCH*CW-1:0]            delay,
  input  logic [NCH-1:0]               abort,
  input  logic                         abort_all,
  output logic [NCH-1:0]               fire,
  output logic                         busy,
  output logic                         done,
`ifdef FJT_ELAPSED_EN
  output logic [CW+$clog2(NCH)+1-1:0]  elapsed,
`endif
  output logic                         aborted
);

  fjt_state_e     state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] fire_q, fire_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;
  logic           abt_q, abt_d;

  logic           running;
  logic           launch;
  logic [NCH-1:0] seq_sel;
  logic [NCH-1:0] chan_en;
  logic [NCH-1:0] chan_kill;
  logic [NCH-1:0] chan_exp;
  logic [NCH-1:0] chan_done;

  assign running = (state_q == ST_RUN_PAR) || (state_q == ST_RUN_SEQ);
  // abt_q marks the trailing busy cycle of an abort_all, so a start there is still ignored.
  assign launch  = (state_q == ST_IDLE) && !abt_q && start;

  // In chained mode the active channel is simply the lowest one still pending.
  assign seq_sel   = pend_q & (~pend_q + NCH'(1));
  assign chan_en   = !running ? '0 : ((state_q == ST_RUN_PAR) ? pend_q : seq_sel);
  assign chan_kill = running ? ((abort & pend_q) | {NCH{abort_all}}) : '0;
  assign chan_done = chan_exp | (abort & pend_q);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    fjt_chan_timer #(
      .CW(CW)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (launch),
      .load_val_i (delay[i*CW +: CW]),
      .en_i       (chan_en[i]),
      .kill_i     (chan_kill[i]),
      .expire_o   (chan_exp[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    fire_d    = '0;
    done_d    = 1'b0;
    aborted_d = abt_q;
    abt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          pend_d = ch_en;
          if (ch_en == '0) begin
            state_d = ST_JOIN;
          end else if (mode == MODE_PAR) begin
            state_d = ST_RUN_PAR;
          end else begin
            state_d = ST_RUN_SEQ;
          end
        end
      end
      ST_RUN_PAR, ST_RUN_SEQ: begin
        if (abort_all) begin
          state_d = ST_IDLE;
          pend_d  = '0;
          abt_d   = 1'b1;
        end else begin
          fire_d = chan_exp;
          pend_d = pend_q & ~chan_done;
          if (pend_d == '0) begin
            state_d = ST_JOIN;
          end
        end
      end
      ST_JOIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      fire_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      fire_q    <= fire_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      abt_q     <= abt_d;
    end
  end

  assign fire    = fire_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign busy    = (state_q != ST_IDLE) || abt_q;

`ifdef FJT_ELAPSED_EN
  localparam int EW = CW + $clog2(NCH) + 1;

  logic [EW-1:0] elapsed_q, elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (launch) begin
      elapsed_d = '0;
    end else if (busy) begin
      elapsed_d = elapsed_q + EW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed = elapsed_q;
`endif

endmodule

// File: tb/tb_fork_join_timer.sv
// Directed bench for fork_join_timer (NCH=4, CW=8): event-time model checked every cycle.
module tb_fork_join_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [3:0]  ch_en;
  logic [31:0] delay;
  logic [3:0]  abort;
  logic        abort_all;
  logic [3:0]  fire;
  logic        busy;
  logic        done;
  logic        aborted;
`ifdef FJT_ELAPSED_EN
  logic [10:0] elapsed;
`endif

  int checks = 0;
  int failures = 0;

  // scenario description: edges are counted from the start edge (edge 0); 0 means "never"
  bit       sc_par;
  bit       sc_hold;
  logic [3:0] sc_en;
  int       sc_d[4];
  int       sc_ab[4];
  int       sc_aa;
  int       sc_rst;

  // model results: cycle of each event, -1 when it must not occur
  int f_t[4];
  int done_t;
  int abt_t;
  int busy_end;

  fork_join_timer #(.NCH(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .ch_en     (ch_en),
    .delay     (delay),
    .abort     (abort),
    .abort_all (abort_all),
    .fire      (fire),
    .busy      (busy),
    .done      (done),
`ifdef FJT_ELAPSED_EN
    .elapsed   (elapsed),
`endif
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic pin(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL model_%s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic set_sc(input bit par, input logic [3:0] en, input int d0, input int d1,
                        input int d2, input int d3);
    sc_par = par; sc_en = en;
    sc_d[0] = d0; sc_d[1] = d1; sc_d[2] = d2; sc_d[3] = d3;
    for (int i = 0; i < 4; i++) sc_ab[i] = 0;
    sc_aa = 0; sc_rst = 0; sc_hold = 1'b0;
  endtask

  // Event times straight from the rules: parallel channels finish at their own delay, chained
  // ones one after another; an abort finishes a channel at the abort edge without a fire.
  task automatic build_model();
    int t, maxc, d, f, c;
    t = 0; maxc = 0; abt_t = -1;
    for (int i = 0; i < 4; i++) begin
      f_t[i] = -1;
      if (sc_en[i]) begin
        d = (sc_d[i] == 0) ? 1 : sc_d[i];
        f = sc_par ? d : t + d;
        if (sc_ab[i] > 0 && sc_ab[i] <= f) begin
          c = sc_ab[i];
        end else begin
          c = f;
          f_t[i] = f;
        end
        if (!sc_par && c > t) t = c;
        if (c > maxc) maxc = c;
      end
    end
    done_t = maxc + 1;
    busy_end = done_t;
    if (sc_aa > 0 && sc_aa <= maxc) begin
      abt_t = sc_aa + 1;
      busy_end = abt_t;
      done_t = -1;
      for (int i = 0; i < 4; i++) if (f_t[i] >= sc_aa) f_t[i] = -1;
    end
  endtask

  task automatic run(input int gap);
    int ncyc;
    logic [3:0] ef;
    bit cut;
    build_model();
    ncyc = busy_end + gap;
    start = 1'b1; mode = sc_par; ch_en = sc_en;
    delay = {8'(sc_d[3]), 8'(sc_d[2]), 8'(sc_d[1]), 8'(sc_d[0])};
    abort = '0; abort_all = 1'b0; rst = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      @(posedge clk); #1;
      cut = (sc_rst > 0) && (k >= sc_rst);
      for (int i = 0; i < 4; i++) ef[i] = (f_t[i] == k) && !cut;
      chk("fire", k, 32'(fire), 32'(ef));
      chk("busy", k, 32'(busy), 32'((k < busy_end) && !cut));
      chk("done", k, 32'(done), 32'((k == done_t) && !cut));
      chk("aborted", k, 32'(aborted), 32'((k == abt_t) && !cut));
`ifdef FJT_ELAPSED_EN
      chk("elapsed", k, 32'(elapsed), cut ? 32'd0 : 32'((k < busy_end) ? k : busy_end));
`endif
      start = sc_hold && (k + 1 <= busy_end);
      if (sc_hold) begin
        ch_en = ~sc_en; mode = ~sc_par; delay = 32'hA5A5_A5A5;
      end
      for (int i = 0; i < 4; i++) abort[i] = (sc_ab[i] == k + 1);
      abort_all = (sc_aa == k + 1);
      rst = (sc_rst == k + 1);
    end
    start = 1'b0; abort = '0; abort_all = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; mode = 1'b1; ch_en = 4'hF; delay = 32'h0505_0505;
    abort = '0; abort_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fire", -1, 32'(fire), 32'd0);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    chk("rst_done", -1, 32'(done), 32'd0);
    chk("rst_aborted", -1, 32'(aborted), 32'd0);
`ifdef FJT_ELAPSED_EN
    chk("rst_elapsed", -1, 32'(elapsed), 32'd0);
`endif
    rst = 1'b0; start = 1'b0; abort = 4'hF; abort_all = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", -1, 32'(busy), 32'd0);
    chk("idle_aborted", -1, 32'(aborted), 32'd0);
    chk("idle_fire", -1, 32'(fire), 32'd0);
    abort = '0; abort_all = 1'b0;

    // parallel, start/mode/mask/delays disturbed mid-run
    set_sc(1'b1, 4'hF, 3, 7, 2, 5); sc_hold = 1'b1;
    run(2);
    pin("par_f0", f_t[0], 3); pin("par_f1", f_t[1], 7); pin("par_f2", f_t[2], 2);
    pin("par_f3", f_t[3], 5); pin("par_done", done_t, 8);

    set_sc(1'b0, 4'hF, 3, 7, 2, 5);
    run(1);
    pin("seq_f1", f_t[1], 10); pin("seq_f3", f_t[3], 17); pin("seq_done", done_t, 18);

    set_sc(1'b1, 4'hF, 3, 7, 2, 5); sc_ab[1] = 4;
    run(1);
    pin("pab_f1", f_t[1], -1); pin("pab_done", done_t, 6);

    // abort_all, then a start in the cycle right after aborted
    set_sc(1'b0, 4'hF, 3, 7, 2, 5); sc_aa = 5;
    run(0);
    pin("aa_aborted", abt_t, 6); pin("aa_done", done_t, -1);

    set_sc(1'b0, 4'b1011, 0, 0, 4, 0);
    run(1);
    pin("z_f0", f_t[0], 1); pin("z_f1", f_t[1], 2); pin("z_f2", f_t[2], -1);
    pin("z_f3", f_t[3], 3); pin("z_done", done_t, 4);

    // empty mask, then a start in the cycle right after done
    set_sc(1'b1, 4'b0000, 3, 7, 2, 5);
    run(0);
    pin("empty_done", done_t, 1);

    set_sc(1'b1, 4'hF, 3, 7, 2, 5); sc_rst = 4;
    run(3);

    // abort of the active chained channel hands over at the next edge
    set_sc(1'b0, 4'hF, 2, 3, 4, 1); sc_ab[1] = 3;
    run(1);
    pin("sab_f2", f_t[2], 7); pin("sab_done", done_t, 9);

    // abort_all on the same edge as a fire wins
    set_sc(1'b1, 4'hF, 2, 5, 1, 9); sc_aa = 2;
    run(2);
    pin("aap_f0", f_t[0], -1); pin("aap_f2", f_t[2], 1); pin("aap_aborted", abt_t, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
